// File: rtl/ppc_pkg.sv
// Shared types for the multimode ping-pong counter.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package ppc_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'd0,
        MODE_WRAP    = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Raw mode code 3 is unassigned and behaves as bounce.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'd1:    m = MODE_WRAP;
            2'd2:    m = MODE_ONESHOT;
            default: m = MODE_BOUNCE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ppc_dwell_timer.sv
// Dwell counter: counts enabled cycles spent parked at a bounce bound.
// Latency: count updates on the edge after i_start/i_inc; o_expire is combinational on the count.
// Backpressure: none; caller simply withholds i_inc to freeze the count.
module ppc_dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_start,
    input  logic               i_inc,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_expire
);

    logic [DWELL_W-1:0] r_count;

    // Clear wins over start, start wins over increment; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= DWELL_W'(1);
        end else if (i_inc) begin
            r_count <= r_count + DWELL_W'(1);
        end
    end

    assign o_expire = (r_count == i_dwell);

endmodule

// File: rtl/multimode_ping_pong_counter.sv
// Up/down counter sweeping [min,max] with programmable step, bounce/wrap/one-shot modes and bound dwell.
// Latency: 1 cycle from sampled inputs to all registered outputs.
// Backpressure: enable=0 freezes counter and dwell count; load is honoured regardless.
module multimode_ping_pong_counter
    import ppc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               flip,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic [WIDTH-1:0]   max,
    input  logic [WIDTH-1:0]   min,
    input  logic [WIDTH-1:0]   step,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic               direction,
    output logic [WIDTH-1:0]   out,
    output logic               turn,
    output logic               done
);

    state_e           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_dir;
    logic             r_turn;
    logic             r_done;

    mode_e            w_mode;
    logic             w_bounce;
    logic             w_range_bad;
    logic             w_active;
    logic             w_bound;
    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_min_plus_step;
    logic [WIDTH-1:0] w_up_next;
    logic [WIDTH-1:0] w_dn_next;
    logic [WIDTH-1:0] w_step_cur;
    logic [WIDTH-1:0] w_step_rev;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_expire;
    logic             w_tmr_clr;
    logic             w_tmr_start;
    logic             w_tmr_inc;

    assign w_mode   = decode_mode(mode);
    assign w_bounce = (w_mode == MODE_BOUNCE);

    // A counter outside the current window (or an empty window) is frozen until bounds make sense again.
    assign w_range_bad = (max <= min) || (r_out < min) || (r_out > max);
    assign w_active    = !rst && !load && enable && !w_range_bad;
    assign w_bound     = r_dir ? (r_out == max) : (r_out == min);

    // Saturating step computed one bit wider so out+step cannot silently wrap.
    assign w_up_sum        = {1'b0, r_out} + {1'b0, step};
    assign w_min_plus_step = {1'b0, min} + {1'b0, step};
    assign w_up_next       = (w_up_sum <= {1'b0, max}) ? w_up_sum[WIDTH-1:0] : max;
    assign w_dn_next       = ({1'b0, r_out} >= w_min_plus_step) ? (r_out - step) : min;
    assign w_step_cur      = r_dir ? w_up_next : w_dn_next;
    assign w_step_rev      = r_dir ? w_dn_next : w_up_next;

    assign w_load_clamped = (load_value < min) ? min :
                            (load_value > max) ? max : load_value;

    // Timer control mirrors the FSM decisions below: start on a bounce bound with nonzero dwell,
    // advance while parked, clear on leaving DWELL or on load.
    assign w_tmr_start = w_active && (r_state == ST_RUN) && !flip && w_bound &&
                         w_bounce && (dwell != '0);
    assign w_tmr_inc   = w_active && (r_state == ST_DWELL) && w_bounce && !w_expire;
    assign w_tmr_clr   = load || (w_active && (r_state == ST_DWELL) && (!w_bounce || w_expire));

    ppc_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_start  (w_tmr_start),
        .i_inc    (w_tmr_inc),
        .i_dwell  (dwell),
        .o_expire (w_expire)
    );

    // Main state machine: reset > load > hold (disabled or bad range) > flip > bound handling > count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_out   <= min;
            r_dir   <= 1'b1;
            r_turn  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_turn <= 1'b0;
            if (load) begin
                r_out   <= w_load_clamped;
                r_dir   <= 1'b1;
                r_state <= ST_RUN;
                r_done  <= 1'b0;
            end else if (w_active) begin
                case (r_state)
                    ST_RUN: begin
                        if (flip) begin
                            r_dir <= ~r_dir;
                            r_out <= w_step_rev;
                        end else if (w_bound) begin
                            case (w_mode)
                                MODE_WRAP: begin
                                    r_out  <= r_dir ? min : max;
                                    r_turn <= 1'b1;
                                end
                                MODE_ONESHOT: begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                    r_turn  <= 1'b1;
                                end
                                default: begin
                                    if (dwell == '0) begin
                                        r_dir  <= ~r_dir;
                                        r_out  <= w_step_rev;
                                        r_turn <= 1'b1;
                                    end else begin
                                        r_state <= ST_DWELL;
                                    end
                                end
                            endcase
                        end else begin
                            r_out <= w_step_cur;
                        end
                    end
                    ST_DWELL: begin
                        if (!w_bounce) begin
                            r_state <= ST_RUN;
                        end else if (w_expire) begin
                            r_dir   <= ~r_dir;
                            r_out   <= w_step_rev;
                            r_turn  <= 1'b1;
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        // DONE is sticky until load or reset.
                    end
                endcase
            end
        end
    end

    assign direction = r_dir;
    assign out       = r_out;
    assign turn      = r_turn;
    assign done      = r_done;

endmodule

// File: tb/tb_multimode_ping_pong_counter.sv
// Scoreboard bench for multimode_ping_pong_counter using directed, hand-computed vectors.
// Stimulus pushes the expected post-edge outputs; a monitor pops and compares after each rising edge.
// The bench runs a fixed number of cycles, so it always reaches its summary.
module tb_multimode_ping_pong_counter;

    typedef struct packed {
        logic [3:0] out;
        logic       dir;
        logic       turn;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       flip;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] max_v;
    logic [3:0] min_v;
    logic [3:0] step;
    logic [1:0] mode;
    logic [3:0] dwell;
    logic       w_direction;
    logic [3:0] w_out;
    logic       w_turn;
    logic       w_done;

    exp_t  q_exp[$];
    string q_name[$];
    int    checks   = 0;
    int    failures = 0;
    logic  prev_turn = 1'b0;

    always #5 clk = ~clk;

    multimode_ping_pong_counter #(
        .WIDTH   (4),
        .DWELL_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .flip       (flip),
        .load       (load),
        .load_value (load_value),
        .max        (max_v),
        .min        (min_v),
        .step       (step),
        .mode       (mode),
        .dwell      (dwell),
        .direction  (w_direction),
        .out        (w_out),
        .turn       (w_turn),
        .done       (w_done)
    );

    // Queue the expected outputs for the coming edge, then move to the next falling edge.
    task automatic cyc(input string nm, input logic [3:0] o, input logic d,
                       input logic t, input logic dn);
        exp_t e;
        e.out  = o;
        e.dir  = d;
        e.turn = t;
        e.done = dn;
        q_exp.push_back(e);
        q_name.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: compare every registered output after each rising edge against the scoreboard.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (prev_turn) begin
                checks++;
                if (w_turn) begin
                    failures++;
                    $display("FAIL turn_pulse_width: turn=%0b on consecutive cycles, required 0", w_turn);
                end
            end
            prev_turn = w_turn;
            if (q_exp.size() > 0) begin
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                checks++;
                if (w_out !== e.out || w_direction !== e.dir || w_turn !== e.turn || w_done !== e.done) begin
                    failures++;
                    $display("FAIL %s: got out=%0d dir=%0b turn=%0b done=%0b, want out=%0d dir=%0b turn=%0b done=%0b",
                             nm, w_out, w_direction, w_turn, w_done, e.out, e.dir, e.turn, e.done);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; flip = 1'b0; load = 1'b0; load_value = 4'd0;
        max_v = 4'd4; min_v = 4'd0; step = 4'd1; mode = 2'd0; dwell = 4'd0;

        // Bounce 0..4, step 1, no dwell
        cyc("t1_reset", 4'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("t1_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("t1_c2", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc("t1_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc("t1_c4", 4'd4, 1'b1, 1'b0, 1'b0);
        cyc("t1_turn_top", 4'd3, 1'b0, 1'b1, 1'b0);
        cyc("t1_c6", 4'd2, 1'b0, 1'b0, 1'b0);
        cyc("t1_c7", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("t1_c8", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc("t1_turn_bot", 4'd1, 1'b1, 1'b1, 1'b0);
        cyc("t1_c10", 4'd2, 1'b1, 1'b0, 1'b0);

        // Bounce 1..10, step 4, dwell 2, with enable gap and reset inside DWELL
        rst = 1'b1; min_v = 4'd1; max_v = 4'd10; step = 4'd4; dwell = 4'd2;
        cyc("t2_reset", 4'd1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("t2_c1", 4'd5, 1'b1, 1'b0, 1'b0);
        cyc("t2_c2", 4'd9, 1'b1, 1'b0, 1'b0);
        cyc("t2_sat_max", 4'd10, 1'b1, 1'b0, 1'b0);
        cyc("t2_dwell1", 4'd10, 1'b1, 1'b0, 1'b0);
        cyc("t2_dwell2", 4'd10, 1'b1, 1'b0, 1'b0);
        cyc("t2_turn_top", 4'd6, 1'b0, 1'b1, 1'b0);
        cyc("t2_c7", 4'd2, 1'b0, 1'b0, 1'b0);
        cyc("t2_sat_min", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("t2_dwell_b1", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("t2_dwell_b2", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("t2_turn_bot", 4'd5, 1'b1, 1'b1, 1'b0);
        cyc("t2_c12", 4'd9, 1'b1, 1'b0, 1'b0);
        cyc("t2_c13", 4'd10, 1'b1, 1'b0, 1'b0);
        cyc("t2_dwell_en1", 4'd10, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) cyc("t2_dwell_frozen", 4'd10, 1'b1, 1'b0, 1'b0);
        enable = 1'b1;
        cyc("t2_dwell_resume", 4'd10, 1'b1, 1'b0, 1'b0);
        cyc("t2_turn_after_gap", 4'd6, 1'b0, 1'b1, 1'b0);
        cyc("t2_c19", 4'd2, 1'b0, 1'b0, 1'b0);
        cyc("t2_c20", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("t2_c21", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("t2_c22", 4'd1, 1'b0, 1'b0, 1'b0);
        cyc("t2_c23", 4'd5, 1'b1, 1'b1, 1'b0);
        cyc("t2_c24", 4'd9, 1'b1, 1'b0, 1'b0);
        cyc("t2_c25", 4'd10, 1'b1, 1'b0, 1'b0);
        cyc("t2_c26_dwell", 4'd10, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc("t2_rst_in_dwell", 4'd1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("t2_after_rst", 4'd5, 1'b1, 1'b0, 1'b0);

        // Wrap 2..5, flip, invalid range, load vs flip
        rst = 1'b1; mode = 2'd1; min_v = 4'd2; max_v = 4'd5; step = 4'd1; dwell = 4'd0;
        cyc("t3_reset", 4'd2, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("t3_c1", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc("t3_c2", 4'd4, 1'b1, 1'b0, 1'b0);
        cyc("t3_c3", 4'd5, 1'b1, 1'b0, 1'b0);
        cyc("t3_wrap_up", 4'd2, 1'b1, 1'b1, 1'b0);
        cyc("t3_c5", 4'd3, 1'b1, 1'b0, 1'b0);
        flip = 1'b1;
        cyc("t3_flip", 4'd2, 1'b0, 1'b0, 1'b0);
        flip = 1'b0;
        cyc("t3_wrap_down", 4'd5, 1'b0, 1'b1, 1'b0);
        cyc("t3_c8", 4'd4, 1'b0, 1'b0, 1'b0);
        max_v = 4'd2; min_v = 4'd5;
        cyc("t3_inv_hold1", 4'd4, 1'b0, 1'b0, 1'b0);
        cyc("t3_inv_hold2", 4'd4, 1'b0, 1'b0, 1'b0);
        min_v = 4'd6; max_v = 4'd9;
        cyc("t3_out_of_window", 4'd4, 1'b0, 1'b0, 1'b0);
        min_v = 4'd2; max_v = 4'd5; load = 1'b1; load_value = 4'd3; flip = 1'b1;
        cyc("t3_load_beats_flip", 4'd3, 1'b1, 1'b0, 1'b0);
        load = 1'b0; flip = 1'b0;
        cyc("t3_after_load", 4'd4, 1'b1, 1'b0, 1'b0);

        // One-shot 0..3, clamp on load, load while disabled
        rst = 1'b1; mode = 2'd2; min_v = 4'd0; max_v = 4'd3; step = 4'd1;
        cyc("t4_reset", 4'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("t4_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        cyc("t4_c2", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc("t4_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc("t4_done", 4'd3, 1'b1, 1'b1, 1'b1);
        cyc("t4_done_hold1", 4'd3, 1'b1, 1'b0, 1'b1);
        cyc("t4_done_hold2", 4'd3, 1'b1, 1'b0, 1'b1);
        flip = 1'b1;
        cyc("t4_flip_in_done", 4'd3, 1'b1, 1'b0, 1'b1);
        flip = 1'b0; load = 1'b1; load_value = 4'd7;
        cyc("t4_load_clamp", 4'd3, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        cyc("t4_done_again", 4'd3, 1'b1, 1'b1, 1'b1);
        load = 1'b1; load_value = 4'd1; enable = 1'b0;
        cyc("t4_load_disabled", 4'd1, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        cyc("t4_disabled_hold", 4'd1, 1'b1, 1'b0, 1'b0);

        // Mode code 3 behaves as bounce; step 2 over 0..3
        rst = 1'b1; enable = 1'b1; mode = 2'd3; min_v = 4'd0; max_v = 4'd3; step = 4'd2;
        cyc("t5_reset", 4'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("t5_c1", 4'd2, 1'b1, 1'b0, 1'b0);
        cyc("t5_sat_max", 4'd3, 1'b1, 1'b0, 1'b0);
        cyc("t5_turn_top", 4'd1, 1'b0, 1'b1, 1'b0);
        cyc("t5_sat_min", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc("t5_turn_bot", 4'd2, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multimode_ping_pong_counter.md
# multimode_ping_pong_counter

Second-generation ping-pong counter: a WIDTH-bit up/down counter bouncing between runtime bounds `min`/`max`, extended with a programmable step, three traversal modes (bounce, wrap, one-shot), a programmable dwell at each bound, synchronous load and a turn-event pulse. It drives LED/7-segment pattern generators and sweep sources in the lab top levels, replacing the fixed-step ping-pong counter.

## Interface
- `WIDTH`, 4, counter/bound/step width
- `DWELL_W`, 4, width of dwell count
- `clk` in 1, single clock, all state on rising edge
- `rst` in 1, synchronous, active-high reset
- `enable` in 1, advance counter/dwell when 1; hold all state when 0 (load still honoured)
- `flip` in 1, reverse direction this cycle (RUN state only)
- `load` in 1, synchronous load request
- `load_value` in WIDTH, value for `load`
- `max`, `min` in WIDTH, inclusive bounds, unsigned
- `step` in WIDTH, increment magnitude, unsigned
- `mode` in 2, 0 BOUNCE, 1 WRAP, 2 ONESHOT, 3 treated as BOUNCE
- `dwell` in DWELL_W, extra cycles held at a bound (BOUNCE only)
- `direction` out 1, 1 = up, 0 = down
- `out` out WIDTH, counter value
- `turn` out 1, one-cycle pulse on bound event
- `done` out 1, ONESHOT finished

## Operation
- States: RUN, DWELL, DONE. Reset: state RUN, `out`=`min`, `direction`=1, `turn`=0, `done`=0, dwell count 0.
- Priority per edge: `rst` > `load` > `!enable` (hold) > invalid range (hold) > `flip` > normal count.
- Load: `out` := `load_value` clamped to [`min`,`max`]; `direction`:=1; state RUN; `done`:=0; dwell count 0. Acts even when `enable`=0.
- Invalid range: `max`<=`min`, or `out` outside [`min`,`max`]: `out`, `direction`, state held; `turn`=0.
- Saturating step (WIDTH+1-bit arithmetic): up next = `out`+`step` if <= `max` else `max`; down next = `out`-`step` if `out` >= `min`+`step` else `min`. `step`=0 holds value; bound detection still applies.
- Flip (RUN): `direction` := ~`direction`, `out` := saturating step in new direction. No `turn`. Ignored in DWELL/DONE.
- Bound hit = (`direction`=1 and `out`=`max`) or (`direction`=0 and `out`=`min`), evaluated in RUN.
- BOUNCE, bound hit: if `dwell`=0, `direction` toggles, `out` steps in new direction, `turn`=1. Else go DWELL, count:=1, `out` held.
- DWELL: each enabled cycle, if count=`dwell` then turn as above and return to RUN, else count+1. `mode` leaving BOUNCE -> RUN next edge without turning.
- WRAP, bound hit: up -> `out`:=`min`; down -> `out`:=`max`; `direction` unchanged; `turn`=1.
- ONESHOT, bound hit: state DONE, `done`:=1, `turn`=1, `out` held. DONE exits only on `load` or `rst`.
- Non-bound cycles in RUN: `out` := saturating step in `direction`.

## Timing
- All outputs registered; inputs sampled at a rising edge take effect on outputs after that edge (1-cycle latency).
- `out` stays at a BOUNCE bound for `dwell`+1 enabled cycles.
- `turn` high exactly one cycle, in the cycle after the bound-event edge; never two consecutive cycles.
- `enable` low during DWELL freezes the dwell count; resumes where left.
- `max`/`min`/`step`/`mode` changes mid-run take effect on next edge; no glitch correction beyond invalid-range hold.
- `rst` mid-DWELL/DONE returns to reset values on that edge.

## Structure
- Package `ppc_pkg`: mode enum (BOUNCE, WRAP, ONESHOT), state enum (RUN, DWELL, DONE).
- Sub-module `ppc_dwell_timer`: DWELL_W counter with clear, enable, `expire` = count equals `dwell`.
- Saturating step logic stays combinational in the top module.

## Test plan
- Reset, WIDTH=4, min=0, max=4, step=1, BOUNCE, dwell=0: `out` 0,1,2,3,4,3,2,1,0,1; `turn` pulses after 4 and 0.
- min=1, max=10, step=4, BOUNCE, dwell=2: `out` 1,5,9,10,10,10,6,2,1,1,1,5.
- WRAP, min=2, max=5, step=1, up: 2,3,4,5,2,3; flip at `out`=3 -> 2,5,4 (wrap down), `direction`=0.
- ONESHOT, min=0, max=3: 0,1,2,3,3 with `done`=1, `turn` one pulse; `load`=7 clamps `out` to 3, `done`=0.
- max=2, min=5 (invalid): `out` held; `enable`=0 mid-DWELL holds count; `load`+`flip` same cycle -> load wins.
- `rst` during DWELL at `out`=`max`: next `out`=`min`, `direction`=1, `turn`=0, `done`=0.
